alu_execute_stage: RTL and testbench

- Execute stage directly downstream of the barrel shifter.
- Takes the shifter's operand-2 result and shifter carry, plus Rn and IR, and performs the 16 ARM data-processing operations or the load/store address add/subtract.
- Evaluates the condition field and owns the architectural NZCV register; its C bit feeds the shifter's carry input.
- Registered output with a valid/ready handshake toward writeback.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_execute_stage_cond_eval.sv | 51 +++++
 rtl/alu_execute_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_execute_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared constants for the ALU execute stage.
//
// Holds the data-processing opcode encodings (IR[24:21]), the condition
// codes (IR[31:28]), the instruction class encodings (IR[27:26]) and the bit
// positions of N, Z, C and V inside the 4-bit flags vector.
// Small helper functions classify opcodes so the top level and any future
// users agree on which ops are compare-only and which use the adder.

package alu_pkg;

  // Data-processing opcodes, IR[24:21]
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Condition codes, IR[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Instruction classes, IR[27:26]
  localparam logic [1:0] CLASS_DP = 2'b00;
  localparam logic [1:0] CLASS_LS = 2'b01;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN: no register write, flags always updated
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Ops whose result and C/V come from the shared adder
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) || (op == OP_ADC) ||
           (op == OP_SBC) || (op == OP_RSC) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_execute_stage_cond_eval.sv
// cond_eval -- purely combinational condition-code evaluator.
//
// Ports:
//   cond  [3:0]  condition field (IR[31:28])
//   flags [3:0]  current architectural {N,Z,C,V}
//   pass         1 when the instruction should execute
//
// Code 1111 is treated as "never" rather than as an unconditional extension
// space, so such instructions simply produce a non-writing entry.

module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = flags[FLAG_N];
  assign z_flag = flags[FLAG_Z];
  assign c_flag = flags[FLAG_C];
  assign v_flag = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_flag;
      COND_NE: pass = !z_flag;
      COND_CS: pass = c_flag;
      COND_CC: pass = !c_flag;
      COND_MI: pass = n_flag;
      COND_PL: pass = !n_flag;
      COND_VS: pass = v_flag;
      COND_VC: pass = !v_flag;
      COND_HI: pass = c_flag && !z_flag;
      COND_LS: pass = !c_flag || z_flag;
      COND_GE: pass = (n_flag == v_flag);
      COND_LT: pass = (n_flag != v_flag);
      COND_GT: pass = !z_flag && (n_flag == v_flag);
      COND_LE: pass = z_flag || (n_flag != v_flag);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;  // COND_NV
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// alu_execute_stage -- ALU execute stage following the barrel shifter.
//
// Performs the 16 data-processing ops, the load/store address add/subtract,
// or a pass-through of the shifter output, gated by the condition field.
// Owns the architectural NZCV register; Flags[1] (C) feeds the shifter's
// carry input. The result is registered behind a valid/ready handshake.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   InValid / InReady  upstream handshake (accept = InValid && InReady)
//   IR, Rn             instruction word and first operand
//   ShOut, ShCarry     shifter result (operand 2) and shifter carry-out
//   OutValid/OutReady  downstream handshake toward writeback
//   Result, RdIdx,     registered result, destination index (IR[15:12])
//   RdWrite            and register-write enable
//   Flags              architectural {N,Z,C,V}
//
// Build option: define ALU_SKID_EN to add a one-entry skid register behind
// the output register. InReady then comes straight from a flop, cutting the
// combinational OutReady->InReady path. Flags always update at accept time.

module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [31:0]          IR,
  input  logic [DATA_W-1:0]    Rn,
  input  logic [DATA_W-1:0]    ShOut,
  input  logic                 ShCarry,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DATA_W-1:0]    Result,
  output logic [REG_IDX_W-1:0] RdIdx,
  output logic                 RdWrite,
  output logic [3:0]           Flags
);

  localparam int MSB = DATA_W - 1;

  // ---------------------------------------------------------------- decode
  logic [1:0] ir_class;
  logic [3:0] opcode;
  logic       s_bit;
  logic       u_bit;
  logic       unused_ir;

  assign ir_class  = IR[27:26];
  assign opcode    = IR[24:21];
  assign s_bit     = IR[20];
  assign u_bit     = IR[23];
  assign unused_ir = ^{IR[25], IR[19:16], IR[11:0]};

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       cond_pass;
  logic       accept;

  cond_eval u_cond_eval (
    .cond  (IR[31:28]),
    .flags (flags_reg),
    .pass  (cond_pass)
  );

  // ------------------------------------------------------- shared adder
  // Every subtract form is built as a + ~b + cin, so the adder carry-out is
  // already the ARM "not borrow" C flag. Load/store reuses the same adder.
  logic [MSB:0]    add_a;
  logic [MSB:0]    add_b;
  logic            add_cin;
  logic [DATA_W:0] add_sum;
  logic            add_v;

  always_comb begin
    add_a   = Rn;
    add_b   = ShOut;
    add_cin = 1'b0;
    if (ir_class == CLASS_LS) begin
      add_b   = u_bit ? ShOut : ~ShOut;
      add_cin = !u_bit;
    end else begin
      case (opcode)
        OP_SUB, OP_CMP: begin
          add_b   = ~ShOut;
          add_cin = 1'b1;
        end
        OP_RSB: begin
          add_a   = ShOut;
          add_b   = ~Rn;
          add_cin = 1'b1;
        end
        OP_ADC: add_cin = flags_reg[FLAG_C];
        OP_SBC: begin
          add_b   = ~ShOut;
          add_cin = flags_reg[FLAG_C];
        end
        OP_RSC: begin
          add_a   = ShOut;
          add_b   = ~Rn;
          add_cin = flags_reg[FLAG_C];
        end
        default: ;  // ADD, CMN and the logical ops: Rn + ShOut
      endcase
    end
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  // Signed overflow: operands of equal sign producing a result of the other sign
  assign add_v   = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);

  // ------------------------------------------------ data-processing result
  logic [MSB:0] dp_result;

  always_comb begin
    dp_result = add_sum[MSB:0];
    case (opcode)
      OP_AND, OP_TST: dp_result = Rn & ShOut;
      OP_EOR, OP_TEQ: dp_result = Rn ^ ShOut;
      OP_ORR:         dp_result = Rn | ShOut;
      OP_MOV:         dp_result = ShOut;
      OP_BIC:         dp_result = Rn & ~ShOut;
      OP_MVN:         dp_result = ~ShOut;
      default:        dp_result = add_sum[MSB:0];
    endcase
  end

  // ------------------------------------------- entry contents and new flags
  logic [MSB:0]           res_next;
  logic                   wr_next;
  logic [REG_IDX_W-1:0]   rd_idx_next;

  assign rd_idx_next = IR[12 +: REG_IDX_W];

  always_comb begin
    res_next   = '0;
    wr_next    = 1'b0;
    flags_next = flags_reg;
    if (cond_pass) begin
      case (ir_class)
        CLASS_DP: begin
          res_next = dp_result;
          wr_next  = !is_test_op(opcode);
          if (s_bit || is_test_op(opcode)) begin
            flags_next[FLAG_N] = dp_result[MSB];
            flags_next[FLAG_Z] = (dp_result == '0);
            if (is_arith_op(opcode)) begin
              flags_next[FLAG_C] = add_sum[DATA_W];
              flags_next[FLAG_V] = add_v;
            end else begin
              flags_next[FLAG_C] = ShCarry;  // V left as is for logical ops
            end
          end
        end
        CLASS_LS: res_next = add_sum[MSB:0];
        default:  res_next = ShOut;
      endcase
    end
  end

  // ----------------------------------------------------------- flags state
  // Updated on the accept edge so the next instruction sees them at once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flags_reg <= 4'b0000;
    end else if (accept) begin
      flags_reg <= flags_next;
    end
  end

  assign Flags = flags_reg;

  // ----------------------------------------------------- output register(s)
  logic                 out_valid_reg;
  logic [MSB:0]         out_result_reg;
  logic [REG_IDX_W-1:0] out_rd_idx_reg;
  logic                 out_rd_write_reg;

  assign accept = InValid && InReady;

`ifdef ALU_SKID_EN
  logic                 skid_valid_reg;
  logic [MSB:0]         skid_result_reg;
  logic [REG_IDX_W-1:0] skid_rd_idx_reg;
  logic                 skid_rd_write_reg;

  // The skid only fills while the output is full, so when it is occupied no
  // accept can happen and it simply waits for the output to drain.
  assign InReady = !skid_valid_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_reg     <= 1'b0;
      out_result_reg    <= '0;
      out_rd_idx_reg    <= '0;
      out_rd_write_reg  <= 1'b0;
      skid_valid_reg    <= 1'b0;
      skid_result_reg   <= '0;
      skid_rd_idx_reg   <= '0;
      skid_rd_write_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      if (OutReady) begin
        out_result_reg   <= skid_result_reg;
        out_rd_idx_reg   <= skid_rd_idx_reg;
        out_rd_write_reg <= skid_rd_write_reg;
        skid_valid_reg   <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg || OutReady) begin
        out_valid_reg    <= 1'b1;
        out_result_reg   <= res_next;
        out_rd_idx_reg   <= rd_idx_next;
        out_rd_write_reg <= wr_next;
      end else begin
        skid_valid_reg    <= 1'b1;
        skid_result_reg   <= res_next;
        skid_rd_idx_reg   <= rd_idx_next;
        skid_rd_write_reg <= wr_next;
      end
    end else if (OutReady) begin
      out_valid_reg <= 1'b0;
    end
  end
`else
  // A drain and a new accept may share the same edge.
  assign InReady = !out_valid_reg || OutReady;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_reg    <= 1'b0;
      out_result_reg   <= '0;
      out_rd_idx_reg   <= '0;
      out_rd_write_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg    <= 1'b1;
      out_result_reg   <= res_next;
      out_rd_idx_reg   <= rd_idx_next;
      out_rd_write_reg <= wr_next;
    end else if (OutReady) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

  assign OutValid = out_valid_reg;
  assign Result   = out_result_reg;
  assign RdIdx    = out_rd_idx_reg;
  assign RdWrite  = out_rd_write_reg;

endmodule

// File: tb/tb_alu_execute_stage.sv
// tb_alu_execute_stage -- scoreboard bench for alu_execute_stage.
//
// A driver issues directed and random instructions; at each accept it asks a
// plain-arithmetic reference model for the expected entry, pushes it into a
// queue and checks Flags. A separate monitor pops and compares every entry
// the DUT hands downstream, and checks that stalled outputs stay stable.

module tb_alu_execute_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] IR;
  logic [31:0] Rn;
  logic [31:0] ShOut;
  logic        ShCarry;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic [3:0]  RdIdx;
  logic        RdWrite;
  logic [3:0]  Flags;

  always #5 Clk = ~Clk;

  alu_execute_stage #(.DATA_W(32), .REG_IDX_W(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .IR       (IR),
    .Rn       (Rn),
    .ShOut    (ShOut),
    .ShCarry  (ShCarry),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .RdIdx    (RdIdx),
    .RdWrite  (RdWrite),
    .Flags    (Flags)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  rd_idx;
    bit          rd_write;
    int          id;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] model_flags = 4'b0000;
  bit         rand_ready  = 1'b0;
  int         txn_id      = 0;
  int         errors      = 0;
  int         checks      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: ARM semantics in 64-bit integer arithmetic.
  function automatic void ref_model(input logic [31:0] ir, input logic [31:0] rn,
                                    input logic [31:0] sh, input bit shc,
                                    input logic [3:0] f, output logic [31:0] res,
                                    output bit wr, output logic [3:0] nf);
    bit n, z, c, v, pass, arith, is_add, carry, ovf;
    logic [3:0] op;
    longint unsigned x, y, k, sum;
    longint xs, ys, ks, sr;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (ir[31:28])
      4'd0:  pass = z;
      4'd1:  pass = !z;
      4'd2:  pass = c;
      4'd3:  pass = !c;
      4'd4:  pass = n;
      4'd5:  pass = !n;
      4'd6:  pass = v;
      4'd7:  pass = !v;
      4'd8:  pass = c && !z;
      4'd9:  pass = !c || z;
      4'd10: pass = (n == v);
      4'd11: pass = (n != v);
      4'd12: pass = !z && (n == v);
      4'd13: pass = z || (n != v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    res = 32'h0; wr = 1'b0; nf = f;
    arith = 1'b1; is_add = 1'b1; carry = 1'b0; ovf = 1'b0;
    x = 0; y = 0; k = 0;
    if (!pass) return;
    if (ir[27:26] == 2'b01) begin
      res = ir[23] ? rn + sh : rn - sh;
      return;
    end
    if (ir[27:26] != 2'b00) begin
      res = sh;
      return;
    end
    op = ir[24:21];
    case (op)
      4'h0, 4'h8: begin res = rn & sh;  arith = 1'b0; end
      4'h1, 4'h9: begin res = rn ^ sh;  arith = 1'b0; end
      4'hC:       begin res = rn | sh;  arith = 1'b0; end
      4'hD:       begin res = sh;       arith = 1'b0; end
      4'hE:       begin res = rn & ~sh; arith = 1'b0; end
      4'hF:       begin res = ~sh;      arith = 1'b0; end
      4'h2, 4'hA: begin x = rn; y = sh; k = 0;  is_add = 1'b0; end
      4'h3:       begin x = sh; y = rn; k = 0;  is_add = 1'b0; end
      4'h4, 4'hB: begin x = rn; y = sh; k = 0;  is_add = 1'b1; end
      4'h5:       begin x = rn; y = sh; k = c;  is_add = 1'b1; end
      4'h6:       begin x = rn; y = sh; k = !c; is_add = 1'b0; end
      default:    begin x = sh; y = rn; k = !c; is_add = 1'b0; end
    endcase
    if (arith) begin
      xs = $signed(x[31:0]);
      ys = $signed(y[31:0]);
      ks = longint'(k);
      if (is_add) begin
        sum   = x + y + k;
        res   = sum[31:0];
        carry = (sum >= 64'h1_0000_0000);
        sr    = xs + ys + ks;
      end else begin
        sum   = x - y - k;
        res   = sum[31:0];
        carry = (x >= y + k);
        sr    = xs - ys - ks;
      end
      ovf = (sr != longint'($signed(res)));
    end
    wr = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
    if (ir[20] || !wr) begin
      nf[3] = res[31];
      nf[2] = (res == 32'h0);
      nf[1] = arith ? carry : shc;
      nf[0] = arith ? ovf : f[0];
    end
  endfunction

  function automatic logic [31:0] dp(input logic [3:0] cond, input logic [3:0] op,
                                     input bit s, input logic [3:0] rd);
    return {cond, 2'b00, 1'b0, op, s, 4'h1, rd, 12'h000};
  endfunction

  function automatic logic [31:0] ls(input logic [3:0] cond, input bit u, input logic [3:0] rd);
    return {cond, 2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, 1'b1, 4'h1, rd, 12'h000};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic send(input logic [31:0] ir, input logic [31:0] rn,
                      input logic [31:0] sh, input bit shc);
    bit rdy, done, wr;
    int waited;
    logic [31:0] res;
    logic [3:0] nf;
    done = 1'b0;
    waited = 0;
    IR = ir; Rn = rn; ShOut = sh; ShCarry = shc; InValid = 1'b1;
    while (!done) begin
      #1 rdy = InReady;
      @(posedge Clk);
      if (rdy) begin
        ref_model(ir, rn, sh, shc, model_flags, res, wr, nf);
        sb_q.push_back('{result: res, rd_idx: ir[15:12], rd_write: wr, id: txn_id});
        model_flags = nf;
        txn_id++;
        done = 1'b1;
        #1 check("flags_after_accept", 32'(Flags), 32'(model_flags));
      end
      @(negedge Clk);
      if (!done) begin
        waited++;
        if (waited > 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: InReady stayed 0 for %0d cycles, expected accept", waited);
          done = 1'b1;
        end
      end
    end
    InValid = 1'b0;
  endtask

  // Monitor: compare every handed-off entry, check stall stability.
  initial begin : monitor
    bit ov, ordy, rst, w, pw, prev_stall;
    logic [31:0] r, pr;
    logic [3:0] ri, pri;
    exp_t e;
    prev_stall = 1'b0;
    pr = 0; pri = 0; pw = 0;
    forever begin
      @(negedge Clk);
      #2;
      ov = OutValid; ordy = OutReady; rst = Reset;
      r = Result; ri = RdIdx; w = RdWrite;
      if (prev_stall && !rst) begin
        check("hold_valid", 32'(ov), 32'd1);
        check("hold_result", r, pr);
        check("hold_rd_idx", 32'(ri), 32'(pri));
        check("hold_rd_write", 32'(w), 32'(pw));
      end
      prev_stall = ov && !ordy && !rst;
      pr = r; pri = ri; pw = w;
      @(posedge Clk);
      if (ov && ordy && !rst) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result=0x%08h with no entry expected", r);
        end else begin
          e = sb_q.pop_front();
          check("result", r, e.result);
          check("rd_idx", 32'(ri), 32'(e.rd_idx));
          check("rd_write", 32'(w), 32'(e.rd_write));
          $display("txn %0d: result=0x%08h rd=%0d wr=%0d", e.id, r, ri, w);
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin : ready_gen
    forever begin
      @(negedge Clk);
      if (rand_ready) OutReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] ir;
    int waited;
    Reset = 1'b1; InValid = 1'b0; IR = 0; Rn = 0; ShOut = 0; ShCarry = 0; OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_out_valid", 32'(OutValid), 32'd0);
    check("reset_result", Result, 32'h0);
    check("reset_rd_idx", 32'(RdIdx), 32'd0);
    check("reset_rd_write", 32'(RdWrite), 32'd0);
    check("reset_flags", 32'(Flags), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1 check("reset_in_ready", 32'(InReady), 32'd1);
    @(negedge Clk);

    // ADDS overflow into the sign bit
    send(dp(4'hE, 4'h4, 1'b1, 4'h2), 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("adds_result", Result, 32'h8000_0000);
    check("adds_rd_write", 32'(RdWrite), 32'd1);
    check("adds_flags", 32'(Flags), 32'b1001);
    // MOVS keeps V from the previous op
    send(dp(4'hE, 4'hD, 1'b1, 4'h3), 32'h55, 32'h0, 1'b1);
    check("movs_flags", 32'(Flags), 32'b0111);
    // CMP 3 vs 7: borrow, negative
    send(dp(4'hE, 4'hA, 1'b0, 4'h0), 32'd3, 32'd7, 1'b0);
    check("cmp_rd_write", 32'(RdWrite), 32'd0);
    check("cmp_flags", 32'(Flags), 32'b1000);
    // SUBS 5-5 then ADDEQ back-to-back
    send(dp(4'hE, 4'h2, 1'b1, 4'h4), 32'd5, 32'd5, 1'b0);
    check("subs_result", Result, 32'h0);
    check("subs_flags", 32'(Flags), 32'b0110);
    send(dp(4'h0, 4'h4, 1'b0, 4'h6), 32'd1, 32'd2, 1'b0);
    check("addeq_result", Result, 32'd3);
    check("addeq_rd_write", 32'(RdWrite), 32'd1);
    // ADDNE with Z=1: entry produced, no write, flags unchanged
    send(dp(4'h1, 4'h4, 1'b1, 4'h7), 32'd1, 32'd2, 1'b0);
    check("addne_out_valid", 32'(OutValid), 32'd1);
    check("addne_rd_write", 32'(RdWrite), 32'd0);
    check("addne_result", Result, 32'h0);
    check("addne_flags", 32'(Flags), 32'b0110);

    // Backpressure
    @(negedge Clk);
    OutReady = 1'b0;
    send(dp(4'hE, 4'h4, 1'b0, 4'h5), 32'd1, 32'd2, 1'b0);
`ifdef ALU_SKID_EN
    send(dp(4'hE, 4'h4, 1'b0, 4'h8), 32'd10, 32'd20, 1'b0);
`endif
    IR = dp(4'hE, 4'h4, 1'b0, 4'h9); Rn = 32'd100; ShOut = 32'd200; InValid = 1'b1;
    repeat (3) begin
      #1;
      check("stall_in_ready", 32'(InReady), 32'd0);
      check("stall_out_valid", 32'(OutValid), 32'd1);
      check("stall_result", Result, 32'd3);
      @(negedge Clk);
    end
    OutReady = 1'b1;
`ifndef ALU_SKID_EN
    #1 check("release_in_ready", 32'(InReady), 32'd1);
`endif
    send(dp(4'hE, 4'h4, 1'b0, 4'h9), 32'd100, 32'd200, 1'b0);
    repeat (2) @(negedge Clk);

    // Reset during a stall
    OutReady = 1'b0;
    send(dp(4'hE, 4'h4, 1'b1, 4'hA), 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("pre_reset_flags", 32'(Flags), 32'b0111);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("stall_reset_out_valid", 32'(OutValid), 32'd0);
    check("stall_reset_result", Result, 32'h0);
    check("stall_reset_flags", 32'(Flags), 32'd0);
    check("stall_reset_rd_write", 32'(RdWrite), 32'd0);
    sb_q.delete();
    model_flags = 4'b0000;
    @(negedge Clk);
    Reset = 1'b0;
    OutReady = 1'b1;
    send(ls(4'hE, 1'b0, 4'hB), 32'h100, 32'h4, 1'b0);
    check("ls_result", Result, 32'hFC);
    check("ls_rd_write", 32'(RdWrite), 32'd0);
    check("ls_flags", 32'(Flags), 32'd0);

    // Random phase
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int sel;
      ir = $urandom;
      if ($urandom_range(0, 2) != 0) ir[31:28] = 4'hE;
      sel = $urandom_range(0, 7);
      if (sel < 5)       ir[27:26] = 2'b00;
      else if (sel < 7)  ir[27:26] = 2'b01;
      send(ir, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(negedge Clk);
    OutReady = 1'b1;
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
